// File: rtl/result_frame_encoder_pkg.sv
// Shared constants and types for the result frame encoder.
package result_frame_encoder_pkg;

    localparam int unsigned GATE_BITS_DEFAULT = 5;
    localparam int unsigned MAX_GATES_DEFAULT = 32;

    localparam logic [7:0] FRAME_RESULT = 8'h52;
    localparam logic [7:0] FRAME_FAIL   = 8'h46;
    localparam logic [7:0] FRAME_ERROR  = 8'h45;

    typedef enum logic [3:0] {
        IDLE,
        CAPTURE,
        SEND_HDR,
        SEND_LEN,
        SEND_GATES,
        SEND_SUM,
        SEND_FAIL,
        SEND_ERR,
        DONE
    } state_t;

    // True for every state that offers a byte to the transmitter.
    function automatic logic is_send_state(input state_t s);
        return (s == SEND_HDR) || (s == SEND_LEN) || (s == SEND_GATES) ||
               (s == SEND_SUM) || (s == SEND_FAIL) || (s == SEND_ERR);
    endfunction

endpackage

// File: rtl/result_frame_encoder_if.sv
// Control, gate-capture and transmit handshake bundle of the encoder.
interface result_frame_encoder_if #(
    parameter int unsigned GATE_BITS = result_frame_encoder_pkg::GATE_BITS_DEFAULT
);
    import result_frame_encoder_pkg::*;

    logic                 start;
    logic                 found;
    logic [GATE_BITS-1:0] gate_in;
    logic                 gate_valid;
    logic                 gate_last;
    logic                 gate_ready;
    logic [7:0]           transmit_byte;
    logic                 transmit_ready;
    logic                 transmit_available;
    logic                 busy;
    logic                 done;

    // Upstream side: coordinator/search path plus the UART's ready line.
    modport master (
        output start, found, gate_in, gate_valid, gate_last, transmit_available,
        input  gate_ready, transmit_byte, transmit_ready, busy, done
    );

    // Encoder side.
    modport slave (
        input  start, found, gate_in, gate_valid, gate_last, transmit_available,
        output gate_ready, transmit_byte, transmit_ready, busy, done
    );

endinterface

// File: rtl/result_frame_encoder_sequence_gate_buffer.sv
// Gate storage: append-only synchronous write, combinational indexed read.
module sequence_gate_buffer
    import result_frame_encoder_pkg::*;
#(
    parameter  int unsigned MAX_GATES = MAX_GATES_DEFAULT,
    parameter  int unsigned GATE_BITS = GATE_BITS_DEFAULT,
    localparam int unsigned IDX_W     = $clog2(MAX_GATES),
    localparam int unsigned CNT_W     = $clog2(MAX_GATES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [GATE_BITS-1:0] wr_data,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [GATE_BITS-1:0] rd_data,
    output logic [CNT_W-1:0]     count,
    output logic                 full
);

    logic [GATE_BITS-1:0] mem [MAX_GATES];

    assign full    = (count == CNT_W'(MAX_GATES));
    assign rd_data = mem[rd_idx];

    // Fill level; writes beyond capacity are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_en && !full) begin
            count <= count + CNT_W'(1);
        end
    end

    // Store the gate at the current fill position.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[IDX_W'(count)] <= wr_data;
        end
    end

endmodule

// File: rtl/result_frame_encoder.sv
// Captures a gate sequence (or failure) and emits a framed reply byte by byte.
module result_frame_encoder
    import result_frame_encoder_pkg::*;
#(
    parameter int unsigned MAX_GATES = MAX_GATES_DEFAULT,
    parameter int unsigned GATE_BITS = GATE_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    result_frame_encoder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(MAX_GATES);
    localparam int unsigned CNT_W = $clog2(MAX_GATES + 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     rd_idx;
    logic [CNT_W-1:0]     rd_idx_next;
    logic [7:0]           gate_sum;
    logic [7:0]           gate_sum_next;
    logic                 overflow;
    logic                 overflow_next;
    logic [7:0]           byte_next;
    logic                 buf_clear;
    logic                 buf_wr;
    logic                 buf_full;
    logic [CNT_W-1:0]     count;
    logic [GATE_BITS-1:0] rd_data;
    logic                 gate_xfer;
    logic                 tx_xfer;

    assign gate_xfer = bus.gate_valid && bus.gate_ready;
    assign tx_xfer   = bus.transmit_ready && bus.transmit_available;

    sequence_gate_buffer #(
        .MAX_GATES (MAX_GATES),
        .GATE_BITS (GATE_BITS)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .wr_data (GATE_BITS'(bus.gate_in)),
        .rd_idx  (IDX_W'(rd_idx_next)),
        .rd_data (rd_data),
        .count   (count),
        .full    (buf_full)
    );

    // Next state, datapath updates and the byte to present next cycle.
    always_comb begin
        state_next    = state;
        rd_idx_next   = rd_idx;
        gate_sum_next = gate_sum;
        overflow_next = overflow;
        buf_clear     = 1'b0;
        buf_wr        = 1'b0;
        byte_next     = 8'h00;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    buf_clear     = 1'b1;
                    gate_sum_next = 8'h00;
                    overflow_next = 1'b0;
                    rd_idx_next   = '0;
                    state_next    = bus.found ? CAPTURE : SEND_FAIL;
                end
            end
            CAPTURE: begin
                if (gate_xfer) begin
                    if (buf_full) begin
                        overflow_next = 1'b1;
                    end else begin
                        buf_wr        = 1'b1;
                        gate_sum_next = gate_sum + 8'(bus.gate_in);
                    end
                    // A drop on the final gate still counts as overflow.
                    if (bus.gate_last) begin
                        state_next = (overflow || buf_full) ? SEND_ERR : SEND_HDR;
                    end
                end
            end
            SEND_HDR: begin
                if (tx_xfer) state_next = SEND_LEN;
            end
            SEND_LEN: begin
                if (tx_xfer) begin
                    rd_idx_next = '0;
                    state_next  = SEND_GATES;
                end
            end
            SEND_GATES: begin
                if (tx_xfer) begin
                    rd_idx_next = rd_idx + CNT_W'(1);
                    if (rd_idx == count - CNT_W'(1)) state_next = SEND_SUM;
                end
            end
            SEND_SUM, SEND_FAIL, SEND_ERR: begin
                if (tx_xfer) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            SEND_HDR:   byte_next = FRAME_RESULT;
            SEND_LEN:   byte_next = 8'(count);
            SEND_GATES: byte_next = 8'(rd_data);
            SEND_SUM:   byte_next = 8'(count) + gate_sum;
            SEND_FAIL:  byte_next = FRAME_FAIL;
            SEND_ERR:   byte_next = FRAME_ERROR;
            default:    byte_next = 8'h00;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            rd_idx             <= '0;
            gate_sum           <= 8'h00;
            overflow           <= 1'b0;
            bus.gate_ready     <= 1'b0;
            bus.transmit_ready <= 1'b0;
            bus.transmit_byte  <= 8'h00;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
        end else begin
            state              <= state_next;
            rd_idx             <= rd_idx_next;
            gate_sum           <= gate_sum_next;
            overflow           <= overflow_next;
            bus.gate_ready     <= (state_next == CAPTURE);
            bus.transmit_ready <= is_send_state(state_next);
            bus.transmit_byte  <= byte_next;
            bus.busy           <= (state_next != IDLE) && (state_next != DONE);
            bus.done           <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_result_frame_encoder.sv
// Bench for result_frame_encoder: directed table, reset abort, random frames.
module tb_result_frame_encoder;

    localparam int unsigned MAXG = 4;
    localparam int unsigned GB   = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    result_frame_encoder_if #(.GATE_BITS(GB)) bus ();

    result_frame_encoder #(
        .MAX_GATES (MAXG),
        .GATE_BITS (GB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Byte arrays: element [0] is the rightmost byte of the concatenation.
    typedef struct packed {
        bit               fnd;
        int               n;
        int               stall;
        logic [7:0][7:0]  g;
        int               exp_len;
        logic [9:0][7:0]  exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Reference frame from the reply rules: F, E, or R/len/gates/sum.
    function automatic void model_frame(input bit fnd, input int n, input logic [7:0][7:0] g);
        int sum;
        exp_q.delete();
        if (!fnd) begin
            exp_q.push_back(8'h46);
        end else if (n > int'(MAXG)) begin
            exp_q.push_back(8'h45);
        end else begin
            exp_q.push_back(8'h52);
            exp_q.push_back(8'(n));
            sum = n;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(g[i]);
                sum += int'(g[i]);
            end
            exp_q.push_back(8'(sum % 256));
        end
    endfunction

    task automatic run_frame(input bit fnd, input int n, input logic [7:0][7:0] g,
                             input int stall, input bit poke);
        bit         stalled   = 1'b0;
        bit         done_seen = 1'b0;
        bit         avail;
        logic [7:0] held      = 8'h00;
        int         cyc       = 0;
        int         lim;

        got_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.found = fnd;
        @(negedge clk);
        bus.start = 1'b0;
        bus.found = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);

        if (fnd) begin
            for (int i = 0; i < n; i++) begin
                check("gate_ready_capture", 32'(bus.gate_ready), 1);
                bus.gate_valid = 1'b1;
                bus.gate_in    = g[i][GB-1:0];
                bus.gate_last  = (i == n - 1);
                @(negedge clk);
            end
            bus.gate_valid = 1'b0;
            bus.gate_last  = 1'b0;
        end else begin
            check("gate_ready_fail", 32'(bus.gate_ready), 0);
        end
        check("first_byte_latency", 32'(bus.transmit_ready), 1);

        while (!done_seen && cyc < 200) begin
            if (stalled) begin
                check("stall_ready_held", 32'(bus.transmit_ready), 1);
                check("stall_byte_held", 32'(bus.transmit_byte), 32'(held));
            end
            if (bus.done) begin
                done_seen = 1'b1;
                check("busy_at_done", 32'(bus.busy), 0);
                check("ready_at_done", 32'(bus.transmit_ready), 0);
            end else begin
                check("gate_ready_sending", 32'(bus.gate_ready), 0);
                case (stall)
                    0:       avail = 1'b1;
                    1:       avail = (cyc % 3 == 2);
                    default: avail = 1'($urandom_range(0, 1));
                endcase
                bus.transmit_available = avail;
                if (poke) begin
                    bus.start      = (cyc == 1);
                    bus.found      = ~fnd;
                    bus.gate_valid = 1'($urandom_range(0, 1));
                    bus.gate_in    = GB'($urandom);
                    bus.gate_last  = 1'($urandom_range(0, 1));
                end
                if (bus.transmit_ready && avail) got_q.push_back(bus.transmit_byte);
                stalled = bus.transmit_ready && !avail;
                held    = bus.transmit_byte;
                cyc++;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(done_seen), 1);

        bus.transmit_available = 1'b0;
        bus.start      = 1'b0;
        bus.found      = 1'b0;
        bus.gate_valid = 1'b0;
        bus.gate_last  = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
        check("idle_busy", 32'(bus.busy), 0);

        check("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            check($sformatf("frame_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        logic [7:0][7:0] g;
        bit              fnd;
        int              n;

        // Directed cases with hand-computed replies.
        vecs[0] = '{fnd: 1'b0, n: 0, stall: 0, g: 64'h0, exp_len: 1,
                    exp: {72'h0, 8'h46}};
        vecs[1] = '{fnd: 1'b1, n: 3, stall: 0, g: {40'h0, 8'h0C, 8'h07, 8'h03}, exp_len: 6,
                    exp: {32'h0, 8'h19, 8'h0C, 8'h07, 8'h03, 8'h03, 8'h52}};
        vecs[2] = '{fnd: 1'b1, n: 3, stall: 1, g: {40'h0, 8'h0C, 8'h07, 8'h03}, exp_len: 6,
                    exp: {32'h0, 8'h19, 8'h0C, 8'h07, 8'h03, 8'h03, 8'h52}};
        vecs[3] = '{fnd: 1'b1, n: 6, stall: 0,
                    g: {16'h0, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, exp_len: 1,
                    exp: {72'h0, 8'h45}};
        vecs[4] = '{fnd: 1'b1, n: 4, stall: 1, g: {32'h0, 8'h04, 8'h03, 8'h02, 8'h01}, exp_len: 7,
                    exp: {24'h0, 8'h0E, 8'h04, 8'h03, 8'h02, 8'h01, 8'h04, 8'h52}};
        vecs[5] = '{fnd: 1'b1, n: 1, stall: 0, g: {56'h0, 8'h1F}, exp_len: 4,
                    exp: {48'h0, 8'h20, 8'h1F, 8'h01, 8'h52}};

        reset                  = 1'b1;
        bus.start              = 1'b0;
        bus.found              = 1'b0;
        bus.gate_in            = '0;
        bus.gate_valid         = 1'b0;
        bus.gate_last          = 1'b0;
        bus.transmit_available = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gate_ready", 32'(bus.gate_ready), 0);
        check("rst_transmit_ready", 32'(bus.transmit_ready), 0);
        check("rst_transmit_byte", 32'(bus.transmit_byte), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            exp_q.delete();
            for (int j = 0; j < vecs[k].exp_len; j++) exp_q.push_back(vecs[k].exp[j]);
            run_frame(vecs[k].fnd, vecs[k].n, vecs[k].g, vecs[k].stall, 1'b0);
        end

        // Reset while gate bytes are being sent aborts the frame.
        @(negedge clk);
        bus.start = 1'b1;
        bus.found = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.gate_valid = 1'b1;
            bus.gate_in    = (i == 0) ? GB'(3) : (i == 1) ? GB'(7) : GB'(12);
            bus.gate_last  = (i == 2);
            @(negedge clk);
        end
        bus.gate_valid         = 1'b0;
        bus.gate_last          = 1'b0;
        bus.transmit_available = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_reset_ready", 32'(bus.transmit_ready), 1);
        check("pre_reset_gate_byte", 32'(bus.transmit_byte), 32'h03);
        reset = 1'b1;
        @(negedge clk);
        check("abort_transmit_ready", 32'(bus.transmit_ready), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_gate_ready", 32'(bus.gate_ready), 0);
        reset                  = 1'b0;
        bus.transmit_available = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h46);
        run_frame(1'b0, 0, 64'h0, 0, 1'b0);

        // Random frames against the reference model.
        for (int r = 0; r < 30; r++) begin
            fnd = ($urandom_range(0, 3) != 0);
            n   = $urandom_range(1, 6);
            g   = '0;
            for (int i = 0; i < 8; i++) g[i] = 8'($urandom_range(0, 31));
            model_frame(fnd, n, g);
            run_frame(fnd, n, g, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/result_frame_encoder.md
Name: result_frame_encoder

Overview:
- Sits directly downstream of the coordinator, between the search result path and the UART transmitter.
- On a start pulse it captures either a found gate sequence or a failure indication.
- It buffers the gates and emits one framed reply byte-by-byte over the transmit handshake:
  - success: 'R', length, gates, checksum
  - failure: 'F'
  - overflow: 'E'
- This decouples search completion from UART pacing.

Parameters:
MAX_GATES, 32, capacity of gate buffer (power of two, 2..255)
GATE_BITS, 5, width of one gate code

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse, begins a frame
found  input  1  sampled with start; 1 = sequence follows, 0 = failure
gate_in  input  GATE_BITS  gate code
gate_valid  input  1  gate_in valid this cycle
gate_last  input  1  qualifies gate_valid; marks final gate
gate_ready  output  1  block accepts gates this cycle
transmit_byte  output  8  byte to UART transmitter
transmit_ready  output  1  transmit_byte valid
transmit_available  input  1  transmitter can accept a byte
busy  output  1  high from accepted start until frame fully sent
done  output  1  one-cycle pulse after last byte transfer

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, reset.
- Reset values: gate_ready=0, transmit_ready=0, transmit_byte=0, busy=0, done=0. The state machine returns to IDLE, the buffer count clears, and the overflow flag clears.
- Byte transfer occurs on a cycle where transmit_ready && transmit_available.
  - transmit_byte is held stable while transmit_ready=1 and no transfer has occurred.
  - The next byte (if any) is presented on the cycle after the transfer, with transmit_ready held high.
- Gate transfer occurs on a cycle where gate_valid && gate_ready.
- States:
  - IDLE: start && found -> CAPTURE. start && !found -> SEND_FAIL. busy goes high the cycle after start.
  - CAPTURE: gate_ready=1.
    - Each gate transfer writes gate_in at index count; count increments.
    - A transfer with gate_last -> SEND_HDR (gate_ready drops the next cycle).
    - If count==MAX_GATES and another gate transfers, set overflow and drop the gate. CAPTURE keeps draining until gate_last; then -> SEND_ERR.
  - SEND_HDR: present 0x52 ('R'); on transfer -> SEND_LEN.
  - SEND_LEN: present count (8 bits); on transfer -> SEND_GATES with read index 0.
  - SEND_GATES: present {zero pad, gate[idx]}; on transfer idx++. After the transfer of idx==count-1 -> SEND_SUM.
  - SEND_SUM: present checksum; on transfer -> DONE.
  - SEND_FAIL: present 0x46 ('F'); on transfer -> DONE.
  - SEND_ERR: present 0x45 ('E'); on transfer -> DONE.
  - DONE: done=1 for one cycle, busy=0, transmit_ready=0; -> IDLE.
- Checksum: 8-bit modulo-256 sum of the length byte and all gate bytes, not the header.
- Latency: the first frame byte is presented with transmit_ready=1 on the cycle after the gate_last transfer, or on the cycle after start for failure.
- start while busy is ignored.
- gate_valid outside CAPTURE is ignored.
- gate_last on the very first transfer gives a 1-gate frame. Zero-length frames are not produced.
- transmit_available low indefinitely: the block holds its state and byte; there is no timeout.
- Simultaneous gate_last transfer and overflow: overflow wins, so SEND_ERR.
- reset mid-frame aborts immediately. transmit_ready is 0 on the cycle after reset; no partial frame resumes.

Decomposition:
- Shared package (types.svi):
  - frame byte constants FRAME_RESULT=8'h52, FRAME_FAIL=8'h46, FRAME_ERROR=8'h45
  - GATE_BITS default
  - the encoder state_t enum
- Sub-module sequence_gate_buffer: MAX_GATES x GATE_BITS storage, with synchronous write and combinational read by index. It exposes count and full.

Test Plan:
- Failure frame: start=1, found=0, transmit_available=1 -> exactly one byte 0x46 transferred, done pulse, busy back to 0; gate_ready never high.
- Success frame: found=1, gates 3,7,12 (12 with gate_last), transmit_available=1 -> bytes 0x52,0x03,0x03,0x07,0x0C,0x19, then done.
- Backpressure: same 3-gate frame with transmit_available toggling 1-of-3 cycles -> byte order and values unchanged, transmit_byte stable while stalled, no byte duplicated.
- Overflow: MAX_GATES=4, send 6 gates with last on the 6th -> single byte 0x45, done; gate_ready high throughout capture.
- Full boundary: MAX_GATES=4, exactly 4 gates 1,2,3,4 -> 0x52,0x04,0x01,0x02,0x03,0x04,0x0E.
- Reset mid-frame: assert reset during SEND_GATES -> next cycle transmit_ready=0, busy=0. A new failure start then yields only 0x46.
